// File: rtl/usart_pkg.sv
// Shared definitions for the USART command receiver / reply transmitter pair.
package usart_pkg;

  localparam logic [15:0] BPS_CNT_DEF     = 16'd434;
  localparam logic [15:0] TIMEOUT_CNT_DEF = 16'd13020;
  localparam logic [7:0]  RX_NUM_DEF      = 8'd5;
  localparam logic [7:0]  TX_NUM_DEF      = 8'd5;

  // 1-based byte positions within a command frame
  localparam int unsigned ADDR  = 1;
  localparam int unsigned MOD   = 2;
  localparam int unsigned D_HI  = 3;
  localparam int unsigned D_MID = 4;
  localparam int unsigned D_LO  = 5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_RECV,
    F_CHECK,
    F_DONE
  } frame_state_e;

endpackage

// File: rtl/uart_recv.sv
// Bit-level 8N1 receiver: synchronises uart_rxd, samples at bit centres and
// reports each byte with a one-clock rx_done, or rx_ferr on a bad stop bit.
module uart_recv
  import usart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = BPS_CNT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       rx_done,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam logic [15:0] HALF_END = (BPS_CNT >> 1) - 16'd1;
  localparam logic [15:0] BIT_END  = BPS_CNT - 16'd1;

  rx_state_e   r_state;
  rx_state_e   w_next;
  logic        r_rxd_s1;
  logic        r_rxd_s2;
  logic        r_rxd_s3;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_done;
  logic        r_ferr;
  logic        w_fall;
  logic        w_half;
  logic        w_bit_end;
  logic        w_cnt_clr;
  logic        w_sample;
  logic        w_done;
  logic        w_ferr;

  // Synchroniser resets to the idle level so reset release cannot look like a start bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_s3 <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_s3 <= r_rxd_s2;
    end
  end

  assign w_fall    = r_rxd_s3 & ~r_rxd_s2;
  assign w_half    = (r_clk_cnt == HALF_END);
  assign w_bit_end = (r_clk_cnt == BIT_END);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= RX_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half) w_next = r_rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_bit_end) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr = (r_state == RX_IDLE) ||
                ((r_state == RX_START) && w_half) ||
                (((r_state == RX_DATA) || (r_state == RX_STOP)) && w_bit_end);
    w_sample  = (r_state == RX_DATA) && w_bit_end;
    w_done    = (r_state == RX_STOP) && w_bit_end && r_rxd_s2;
    w_ferr    = (r_state == RX_STOP) && w_bit_end && !r_rxd_s2;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_clk_cnt <= w_cnt_clr ? '0 : r_clk_cnt + 16'd1;
      if (r_state != RX_DATA) r_bit_cnt <= '0;
      else if (w_sample)      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample) r_shift <= {r_rxd_s2, r_shift[7:1]};
      r_done <= w_done;
      r_ferr <= w_ferr;
    end
  end

  assign rx_done = r_done;
  assign rx_byte = r_shift;
  assign rx_ferr = r_ferr;

endmodule

// File: rtl/usart_rx_frame.sv
// Command-frame receiver: collects address / mode / 24-bit data bytes and
// pulses trig on a complete frame. Define RX_CHECKSUM_EN for a trailing XOR byte.
module usart_rx_frame
  import usart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT     = BPS_CNT_DEF,
  parameter logic [7:0]  RX_NUM      = RX_NUM_DEF,
  parameter logic [15:0] TIMEOUT_CNT = TIMEOUT_CNT_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [1:0]  Adress,
  output logic [5:0]  Mod_SEL,
  output logic [23:0] D,
  output logic        trig,
  output logic        frame_err
);

`ifdef RX_CHECKSUM_EN
  localparam int unsigned  FRAME_LEN = int'(RX_NUM) + 1;
  localparam frame_state_e F_FINAL   = F_CHECK;
`else
  localparam int unsigned  FRAME_LEN = int'(RX_NUM);
  localparam frame_state_e F_FINAL   = F_DONE;
`endif
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  logic         w_rx_done;
  logic [7:0]   w_rx_byte;
  logic         w_rx_ferr;
  frame_state_e r_state;
  frame_state_e w_next;
  logic [7:0]   r_cnt;
  logic [7:0]   r_bytes [FRAME_LEN];
  logic [7:0]   w_frame [FRAME_LEN];
  logic [15:0]  r_to_cnt;
  logic [1:0]   r_adress;
  logic [5:0]   r_mod_sel;
  logic [23:0]  r_d;
  logic         r_frame_err;
  logic         w_store;
  logic         w_last;
  logic         w_timeout;
  logic         w_drop;
  logic         w_load;

  uart_recv #(.BPS_CNT(BPS_CNT)) u_uart_recv (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rx_done   (w_rx_done),
    .rx_byte   (w_rx_byte),
    .rx_ferr   (w_rx_ferr)
  );

  assign w_store   = w_rx_done && !w_rx_ferr &&
                     ((r_state == F_IDLE) || (r_state == F_RECV));
  assign w_last    = (r_cnt == LAST_IDX);
  assign w_timeout = (r_state == F_RECV) && (r_to_cnt == TIMEOUT_CNT - 16'd1);

  // Stored bytes with the arriving byte merged in, so outputs load on the same edge
  always_comb begin
    for (int unsigned i = 0; i < FRAME_LEN; i++)
      w_frame[i] = (w_store && (r_cnt == 8'(i))) ? w_rx_byte : r_bytes[i];
  end

`ifdef RX_CHECKSUM_EN
  logic [7:0] w_xor;
  logic       w_chk_ok;
  always_comb begin
    w_xor = '0;
    for (int unsigned i = 0; i < FRAME_LEN - 1; i++)
      w_xor = w_xor ^ r_bytes[i];
    w_chk_ok = (w_xor == r_bytes[FRAME_LEN-1]);
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= F_IDLE;
    else            r_state <= w_next;
  end

  // A received byte outranks a timeout in the same clock; a stop-bit error outranks all
  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    case (r_state)
      F_IDLE: if (w_rx_done) w_next = w_last ? F_FINAL : F_RECV;
      F_RECV: begin
        if (w_rx_done) w_next = w_last ? F_FINAL : F_RECV;
        else if (w_timeout) begin
          w_next = F_IDLE;
          w_drop = 1'b1;
        end
      end
`ifdef RX_CHECKSUM_EN
      F_CHECK: begin
        if (w_chk_ok) w_next = F_DONE;
        else begin
          w_next = F_IDLE;
          w_drop = 1'b1;
        end
      end
`endif
      F_DONE:  w_next = F_IDLE;
      default: w_next = F_IDLE;
    endcase
    if (w_rx_ferr) begin
      w_next = F_IDLE;
      w_drop = 1'b1;
    end
  end

  always_comb begin
    trig   = (r_state == F_DONE);
    w_load = (w_next == F_DONE) && (r_state != F_DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt    <= '0;
      r_to_cnt <= '0;
      for (int unsigned i = 0; i < FRAME_LEN; i++) r_bytes[i] <= '0;
    end else begin
      if (w_drop)       r_cnt <= '0;
      else if (w_store) r_cnt <= w_last ? '0 : r_cnt + 8'd1;
      if (w_store) begin
        for (int unsigned i = 0; i < FRAME_LEN; i++)
          if (r_cnt == 8'(i)) r_bytes[i] <= w_rx_byte;
      end
      if ((r_state != F_RECV) || w_rx_done) r_to_cnt <= '0;
      else                                  r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_adress    <= '0;
      r_mod_sel   <= '0;
      r_d         <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_drop;
      if (w_load) begin
        r_adress  <= w_frame[ADDR-1][1:0];
        r_mod_sel <= w_frame[MOD-1][5:0];
        r_d       <= {w_frame[D_HI-1], w_frame[D_MID-1], w_frame[D_LO-1]};
      end
    end
  end

  assign Adress    = r_adress;
  assign Mod_SEL   = r_mod_sel;
  assign D         = r_d;
  assign frame_err = r_frame_err;

endmodule
